// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_pkg;

  localparam int FQ_XLEN = 32;
  localparam logic [FQ_XLEN-1:0] INST_BUBBLE = 32'd0;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_chk.sv
// Property checker for fetch_queue occupancy and slot-validity ordering.
module fetch_queue_chk #(
  parameter int DEPTH = 8
) (
  input logic                     clk,
  input logic                     reset,
  input logic [$clog2(DEPTH):0]   count,
  input logic                     out_valid1,
  input logic                     out_valid2
);

  // occupancy can never exceed the entry array
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= ($clog2(DEPTH)+1)'(DEPTH));

  // slot 2 is only ever valid behind a valid slot 1
  a_slot_order: assert property (@(posedge clk) disable iff (reset)
    out_valid2 |-> out_valid1);

endmodule

// File: rtl/fetch_queue.sv
// Program-ordered instruction buffer between fetch and decode: drops bubble
// words, presents the two oldest entries fall-through, flushes on redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = FQ_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] inst1,
  input  logic [XLEN-1:0] inst2,
  output logic            fetch_ready,
  input  logic            dec_ready,
  output logic            out_valid1,
  output logic [XLEN-1:0] out_inst1,
  output logic [XLEN-1:0] out_pc1,
  output logic            out_valid2,
  output logic [XLEN-1:0] out_inst2,
  output logic [XLEN-1:0] out_pc2,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t         storage_r [DEPTH];
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;

  logic              v1_s;
  logic              v2_s;
  logic              enq_fire_s;
  logic [1:0]        enq_n_s;
  logic [1:0]        deq_n_s;
  logic [XLEN-1:0]   pc2_s;
  fq_entry_t         wr0_s;
  fq_entry_t         wr1_s;
  logic [PW-1:0]     head_p1_s;
  logic [PW-1:0]     tail_p1_s;

  assign fetch_ready = (count_r <= CW'(DEPTH - 2));
  assign head_p1_s   = head_r + PW'(1);
  assign tail_p1_s   = tail_r + PW'(1);

  // Compact the fetch pair (bubble removal) and size this cycle's enqueue/dequeue
  always_comb begin
    v1_s       = (inst1 != INST_BUBBLE);
    v2_s       = (inst2 != INST_BUBBLE);
    pc2_s      = fetch_pc + XLEN'(INST_BYTES);
    enq_fire_s = fetch_valid && fetch_ready && !flush;
    wr1_s      = '{pc: pc2_s, inst: inst2};
    if (v1_s) begin
      wr0_s = '{pc: fetch_pc, inst: inst1};
    end else begin
      wr0_s = wr1_s;
    end
    if (enq_fire_s) begin
      enq_n_s = {1'b0, v1_s} + {1'b0, v2_s};
    end else begin
      enq_n_s = 2'd0;
    end
    if (dec_ready && !flush) begin
      deq_n_s = (count_r >= CW'(2)) ? 2'd2 : count_r[1:0];
    end else begin
      deq_n_s = 2'd0;
    end
  end

  // Pointer and occupancy state; reset beats flush, flush beats enq/deq
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PW'(deq_n_s);
      tail_r  <= tail_r + PW'(enq_n_s);
      count_r <= count_r + CW'(enq_n_s) - CW'(deq_n_s);
    end
  end

  // Entry array write port; contents are intentionally left uncleared by reset
  always_ff @(posedge clk) begin
    if (!reset && enq_n_s != 2'd0) begin
      storage_r[tail_r] <= wr0_s;
      if (enq_n_s == 2'd2) begin
        storage_r[tail_p1_s] <= wr1_s;
      end
    end
  end

  assign out_valid1 = (count_r >= CW'(1));
  assign out_valid2 = (count_r >= CW'(2));
  assign out_inst1  = storage_r[head_r].inst;
  assign out_pc1    = storage_r[head_r].pc;
  assign out_inst2  = storage_r[head_p1_s].inst;
  assign out_pc2    = storage_r[head_p1_s].pc;
  assign empty      = (count_r == '0);

endmodule
